mlp_inference_sequencer: RTL and testbench

//  Sequences one sample at a time through the combinational printed-MLP classifier (top: inp -> out).
//  Per sample: registers the input vector, waits a programmable settle time, then captures the class.
//  Re-samples the class after a check window and flags any mismatch (glitch/fault detection).

---
 rtl/mlp_inference_sequencer_pkg.sv | 32 +++
 rtl/mlp_inference_sequencer_if.sv | 27 ++
 rtl/mlp_inference_sequencer_settle_timer.sv | 37 +++
 rtl/mlp_inference_sequencer.sv | 158 +++++++++++++++
 tb/tb_mlp_inference_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_inference_sequencer_pkg.sv
// Shared types, default build parameters and helpers for the MLP inference sequencer.
package mlp_seq_pkg;

    localparam int unsigned DEF_NUM_A         = 4;
    localparam int unsigned DEF_WIDTH_A       = 4;
    localparam int unsigned DEF_OUTWIDTH      = 2;
    localparam int unsigned DEF_SETTLE_CYCLES = 8;
    localparam int unsigned DEF_CHECK_CYCLES  = 2;
    localparam int unsigned DEF_CNT_W         = 16;

    localparam int unsigned DATA_W = DEF_NUM_A * DEF_WIDTH_A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        RESULT = 2'd3
    } seq_state_e;

    // Timer width wide enough for the larger of the two reload values; never below 1 bit.
    function automatic int unsigned tmr_width(input int unsigned settle, input int unsigned check);
        int unsigned m;
        m = (settle > check) ? settle : check;
        if (m + 1 <= 2) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

    localparam int unsigned TMR_W = tmr_width(DEF_SETTLE_CYCLES, DEF_CHECK_CYCLES);

endpackage

// File: rtl/mlp_inference_sequencer_if.sv
// Sample-source and result-sink handshake bundle of the sequencer.
interface mlp_inference_sequencer_if
    import mlp_seq_pkg::*;
#(
    parameter int unsigned DW = DATA_W,
    parameter int unsigned OW = DEF_OUTWIDTH
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_inp;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_class;
    logic          m_mismatch;

    // Environment side: drives samples, consumes results.
    modport master (
        output s_valid, s_inp, m_ready,
        input  s_ready, m_valid, m_class, m_mismatch
    );

    // Sequencer side.
    modport slave (
        input  s_valid, s_inp, m_ready,
        output s_ready, m_valid, m_class, m_mismatch
    );
endinterface

// File: rtl/mlp_inference_sequencer_settle_timer.sv
// Loadable down-counter used for both the settle and the check windows.
module settle_timer
    import mlp_seq_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_c_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c_o = (cnt_q == '0);
endmodule

// File: rtl/mlp_inference_sequencer.sv
// Steps one sample at a time through a combinational MLP: load, settle, capture, re-check, deliver.
module mlp_inference_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int unsigned NUM_A         = DEF_NUM_A,
    parameter int unsigned WIDTH_A       = DEF_WIDTH_A,
    parameter int unsigned OUTWIDTH      = DEF_OUTWIDTH,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned CHECK_CYCLES  = DEF_CHECK_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mlp_inference_sequencer_if.slave   bus,
    output logic [NUM_A*WIDTH_A-1:0]   mlp_inp,
    input  logic [OUTWIDTH-1:0]        mlp_out,
    output logic                       busy,
    output logic [CNT_W-1:0]           sample_cnt,
    output logic [CNT_W-1:0]           mismatch_cnt
);
    localparam int unsigned DW = NUM_A * WIDTH_A;
    localparam int unsigned TW = tmr_width(SETTLE_CYCLES, CHECK_CYCLES);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] CHECK_LOAD  = TW'((CHECK_CYCLES != 0) ? CHECK_CYCLES - 1 : 0);
    localparam logic CHECK_EN = (CHECK_CYCLES != 0);

    seq_state_e            state_q, state_d;
    logic [DW-1:0]         mlp_inp_q, mlp_inp_d;
    logic [OUTWIDTH-1:0]   class_a_q, class_a_d;
    logic [OUTWIDTH-1:0]   class_b_q, class_b_d;
    logic                  s_ready_q, s_ready_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_mismatch_q, m_mismatch_d;
    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]      mismatch_cnt_q, mismatch_cnt_d;

    logic                  tmr_load_c;
    logic [TW-1:0]         tmr_load_val_c;
    logic                  tmr_en_c;
    logic                  tmr_zero_c;

    settle_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load_c),
        .load_val_i (tmr_load_val_c),
        .en_i       (tmr_en_c),
        .zero_c_o   (tmr_zero_c)
    );

    // Next-state, capture and statistics logic.
    always_comb begin
        state_d        = state_q;
        mlp_inp_d      = mlp_inp_q;
        class_a_d      = class_a_q;
        class_b_d      = class_b_q;
        m_valid_d      = m_valid_q;
        m_mismatch_d   = m_mismatch_q;
        sample_cnt_d   = sample_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        tmr_load_c     = 1'b0;
        tmr_load_val_c = SETTLE_LOAD;
        tmr_en_c       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.s_valid && s_ready_q) begin
                    mlp_inp_d      = bus.s_inp;
                    tmr_load_c     = 1'b1;
                    tmr_load_val_c = SETTLE_LOAD;
                    state_d        = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_zero_c) begin
                    class_a_d = mlp_out;
                    if (CHECK_EN) begin
                        tmr_load_c     = 1'b1;
                        tmr_load_val_c = CHECK_LOAD;
                        state_d        = CHECK;
                    end else begin
                        class_b_d = mlp_out;
                        state_d   = RESULT;
                    end
                end else begin
                    tmr_en_c = 1'b1;
                end
            end
            CHECK: begin
                if (tmr_zero_c) begin
                    class_b_d = mlp_out;
                    state_d   = RESULT;
                end else begin
                    tmr_en_c = 1'b1;
                end
            end
            RESULT: begin
                if (!m_valid_q) begin
                    m_valid_d    = 1'b1;
                    m_mismatch_d = CHECK_EN && (class_a_q != class_b_q);
                end else if (bus.m_ready) begin
                    m_valid_d    = 1'b0;
                    m_mismatch_d = 1'b0;
                    state_d      = IDLE;
                    if (!(&sample_cnt_q)) begin
                        sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    end
                    if (m_mismatch_q && !(&mismatch_cnt_q)) begin
                        mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        s_ready_d = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mlp_inp_q      <= '0;
            class_a_q      <= '0;
            class_b_q      <= '0;
            s_ready_q      <= 1'b1;
            m_valid_q      <= 1'b0;
            m_mismatch_q   <= 1'b0;
            busy_q         <= 1'b0;
            sample_cnt_q   <= '0;
            mismatch_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            mlp_inp_q      <= mlp_inp_d;
            class_a_q      <= class_a_d;
            class_b_q      <= class_b_d;
            s_ready_q      <= s_ready_d;
            m_valid_q      <= m_valid_d;
            m_mismatch_q   <= m_mismatch_d;
            busy_q         <= busy_d;
            sample_cnt_q   <= sample_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_class    = class_a_q;
    assign bus.m_mismatch = m_mismatch_q;
    assign mlp_inp        = mlp_inp_q;
    assign busy           = busy_q;
    assign sample_cnt     = sample_cnt_q;
    assign mismatch_cnt   = mismatch_cnt_q;
endmodule

// File: tb/tb_mlp_inference_sequencer.sv
// Bench for the MLP inference sequencer: three builds (default, no-check, 2-bit counters).
module tb_mlp_inference_sequencer;
    import mlp_seq_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned OW = 2;

    typedef struct {
        int          d;
        logic [1:0]  cls;
        logic        mm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Bench-driven stimulus, one slot per DUT build
    logic          s_valid [3];
    logic [DW-1:0] s_inp   [3];
    logic          m_ready [3];
    logic [OW-1:0] mlp_out [3];

    // Observed DUT outputs
    logic          s_ready_w    [3];
    logic          m_valid_w    [3];
    logic [OW-1:0] m_class_w    [3];
    logic          m_mismatch_w [3];
    logic          busy_w       [3];
    logic [DW-1:0] mlp_inp_w    [3];
    logic [15:0]   sc_w         [3];
    logic [15:0]   mc_w         [3];

    logic [DW-1:0] inp0, inp1, inp2;
    logic          busy0, busy1, busy2;
    logic [15:0]   sc0, mc0, sc1, mc1;
    logic [1:0]    sc2, mc2;

    mlp_inference_sequencer_if #(.DW(DW), .OW(OW)) if0 ();
    mlp_inference_sequencer_if #(.DW(DW), .OW(OW)) if1 ();
    mlp_inference_sequencer_if #(.DW(DW), .OW(OW)) if2 ();

    assign if0.s_valid = s_valid[0];
    assign if0.s_inp   = s_inp[0];
    assign if0.m_ready = m_ready[0];
    assign if1.s_valid = s_valid[1];
    assign if1.s_inp   = s_inp[1];
    assign if1.m_ready = m_ready[1];
    assign if2.s_valid = s_valid[2];
    assign if2.s_inp   = s_inp[2];
    assign if2.m_ready = m_ready[2];

    assign s_ready_w[0] = if0.s_ready;
    assign s_ready_w[1] = if1.s_ready;
    assign s_ready_w[2] = if2.s_ready;
    assign m_valid_w[0] = if0.m_valid;
    assign m_valid_w[1] = if1.m_valid;
    assign m_valid_w[2] = if2.m_valid;
    assign m_class_w[0] = if0.m_class;
    assign m_class_w[1] = if1.m_class;
    assign m_class_w[2] = if2.m_class;
    assign m_mismatch_w[0] = if0.m_mismatch;
    assign m_mismatch_w[1] = if1.m_mismatch;
    assign m_mismatch_w[2] = if2.m_mismatch;
    assign busy_w[0] = busy0;
    assign busy_w[1] = busy1;
    assign busy_w[2] = busy2;
    assign mlp_inp_w[0] = inp0;
    assign mlp_inp_w[1] = inp1;
    assign mlp_inp_w[2] = inp2;
    assign sc_w[0] = sc0;
    assign sc_w[1] = sc1;
    assign sc_w[2] = 16'(sc2);
    assign mc_w[0] = mc0;
    assign mc_w[1] = mc1;
    assign mc_w[2] = 16'(mc2);

    mlp_inference_sequencer dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0), .mlp_inp(inp0), .mlp_out(mlp_out[0]),
        .busy(busy0), .sample_cnt(sc0), .mismatch_cnt(mc0)
    );

    mlp_inference_sequencer #(.SETTLE_CYCLES(1), .CHECK_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .mlp_inp(inp1), .mlp_out(mlp_out[1]),
        .busy(busy1), .sample_cnt(sc1), .mismatch_cnt(mc1)
    );

    mlp_inference_sequencer #(.SETTLE_CYCLES(3), .CHECK_CYCLES(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2), .mlp_inp(inp2), .mlp_out(mlp_out[2]),
        .busy(busy2), .sample_cnt(sc2), .mismatch_cnt(mc2)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_sc [3];
    int   exp_mc [3];
    exp_t sb [$];

    function automatic int s_of(input int d);
        return (d == 0) ? 8 : (d == 1) ? 1 : 3;
    endfunction

    function automatic int c_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 0 : 1;
    endfunction

    function automatic int cnt_max(input int d);
        return (d == 2) ? 3 : 65535;
    endfunction

    // One full transaction on DUT d; hold>0 stalls the sink in RESULT for that many cycles.
    task automatic run_sample(input int d, input logic [15:0] inp, input logic [1:0] ca,
                              input logic [1:0] cb, input int hold);
        int   s, c, lat, n;
        bit   early, unstable;
        exp_t e;
        s   = s_of(d);
        c   = c_of(d);
        lat = s + c + 1;
        s_valid[d] = 1'b1;
        s_inp[d]   = inp;
        m_ready[d] = (hold == 0);
        mlp_out[d] = 2'($urandom);
        n = 0;
        while (s_ready_w[d] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (s_ready_w[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait dut%0d: s_ready=%b required 1", d, s_ready_w[d]);
            s_valid[d] = 1'b0;
            return;
        end
        e.d   = d;
        e.cls = ca;
        e.mm  = (c != 0) && (ca != cb);
        sb.push_back(e);
        @(posedge clk); #1;
        s_valid[d] = 1'b0;
        n_checks++;
        if (mlp_inp_w[d] !== inp || busy_w[d] !== 1'b1 || s_ready_w[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL load dut%0d: mlp_inp=%h busy=%b s_ready=%b required %h 1 0",
                     d, mlp_inp_w[d], busy_w[d], s_ready_w[d], inp);
        end
        early = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k == s) mlp_out[d] = ca;
            else if (c != 0 && k == s + c) mlp_out[d] = cb;
            else mlp_out[d] = 2'($urandom);
            @(posedge clk); #1;
            if (k < lat && m_valid_w[d] !== 1'b0) early = 1'b1;
        end
        n_checks++;
        if (early || m_valid_w[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL latency dut%0d: early=%b m_valid=%b at edge %0d, required rise exactly there",
                     d, early, m_valid_w[d], lat);
        end
        if (hold > 0) begin
            unstable   = 1'b0;
            s_valid[d] = 1'b1;
            s_inp[d]   = ~inp;
            for (int h = 0; h < hold; h++) begin
                mlp_out[d] = 2'($urandom);
                @(posedge clk); #1;
                if (m_valid_w[d] !== 1'b1 || m_class_w[d] !== ca || s_ready_w[d] !== 1'b0
                    || mlp_inp_w[d] !== inp || busy_w[d] !== 1'b1) unstable = 1'b1;
            end
            s_valid[d] = 1'b0;
            n_checks++;
            if (unstable) begin
                n_fail++;
                $display("FAIL backpressure dut%0d: m_valid=%b m_class=%0d s_ready=%b mlp_inp=%h required 1 %0d 0 %h",
                         d, m_valid_w[d], m_class_w[d], s_ready_w[d], mlp_inp_w[d], ca, inp);
            end
            m_ready[d] = 1'b1;
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty dut%0d: result with no expected entry", d);
        end else begin
            e = sb.pop_front();
            if (e.d != d || m_class_w[d] !== e.cls || m_mismatch_w[d] !== e.mm) begin
                n_fail++;
                $display("FAIL result dut%0d: m_class=%0d m_mismatch=%b required %0d %b",
                         d, m_class_w[d], m_mismatch_w[d], e.cls, e.mm);
            end
            if (exp_sc[d] < cnt_max(d)) exp_sc[d]++;
            if (e.mm && exp_mc[d] < cnt_max(d)) exp_mc[d]++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (m_valid_w[d] !== 1'b0 || s_ready_w[d] !== 1'b1 || busy_w[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL handshake dut%0d: m_valid=%b s_ready=%b busy=%b required 0 1 0",
                     d, m_valid_w[d], s_ready_w[d], busy_w[d]);
        end
        n_checks++;
        if (sc_w[d] !== 16'(exp_sc[d]) || mc_w[d] !== 16'(exp_mc[d])) begin
            n_fail++;
            $display("FAIL counters dut%0d: sample_cnt=%0d mismatch_cnt=%0d required %0d %0d",
                     d, sc_w[d], mc_w[d], exp_sc[d], exp_mc[d]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (s_ready_w[d] !== 1'b1 || m_valid_w[d] !== 1'b0 || m_class_w[d] !== 2'd0
                || m_mismatch_w[d] !== 1'b0 || busy_w[d] !== 1'b0 || mlp_inp_w[d] !== 16'h0
                || sc_w[d] !== 16'h0 || mc_w[d] !== 16'h0) begin
                n_fail++;
                $display("FAIL reset dut%0d: s_ready=%b m_valid=%b m_class=%0d mm=%b busy=%b inp=%h cnt=%0d/%0d required 1 0 0 0 0 0 0/0",
                         d, s_ready_w[d], m_valid_w[d], m_class_w[d], m_mismatch_w[d],
                         busy_w[d], mlp_inp_w[d], sc_w[d], mc_w[d]);
            end
            exp_sc[d] = 0;
            exp_mc[d] = 0;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_sample(0, 16'h2D31, 2'd1, 2'd1, 0);
    endtask

    task automatic test_mismatch();
        run_sample(0, 16'h1A5C, 2'd0, 2'd2, 0);
    endtask

    task automatic test_backpressure();
        run_sample(0, 16'h7E02, 2'd3, 2'd3, 20);
    endtask

    task automatic test_no_check();
        run_sample(1, 16'h0F0F, 2'd2, 2'd1, 0);
        run_sample(1, 16'hC3A5, 2'd1, 2'd3, 3);
        n_checks++;
        if (mc_w[1] !== 16'h0) begin
            n_fail++;
            $display("FAIL no_check_mm: mismatch_cnt=%0d required 0", mc_w[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] a, b;
        for (int i = 0; i < 4; i++) begin
            a = 2'($urandom);
            b = (i % 2 == 0) ? a : ~a;
            run_sample(0, 16'($urandom), a, b, 0);
        end
    endtask

    task automatic test_reset_midflight();
        int n;
        s_valid[0] = 1'b1;
        s_inp[0]   = 16'hBEEF;
        m_ready[0] = 1'b1;
        n = 0;
        while (s_ready_w[0] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        s_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy_w[0] !== 1'b1 || mlp_inp_w[0] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL midflight_busy: busy=%b mlp_inp=%h required 1 beef", busy_w[0], mlp_inp_w[0]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (s_ready_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || m_valid_w[0] !== 1'b0
            || mlp_inp_w[0] !== 16'h0 || sc_w[0] !== 16'h0 || mc_w[0] !== 16'h0) begin
            n_fail++;
            $display("FAIL midflight_reset: s_ready=%b busy=%b m_valid=%b inp=%h cnt=%0d/%0d required 1 0 0 0 0/0",
                     s_ready_w[0], busy_w[0], m_valid_w[0], mlp_inp_w[0], sc_w[0], mc_w[0]);
        end
        for (int d = 0; d < 3; d++) begin
            exp_sc[d] = 0;
            exp_mc[d] = 0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_sample(0, 16'h4411, 2'd2, 2'd2, 0);
        n_checks++;
        if (sc_w[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL midflight_count: sample_cnt=%0d required 1", sc_w[0]);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            run_sample(2, 16'(16'h1000 + i), 2'd1, 2'd2, 0);
        end
        n_checks++;
        if (sc_w[2] !== 16'd3 || mc_w[2] !== 16'd3) begin
            n_fail++;
            $display("FAIL saturation: sample_cnt=%0d mismatch_cnt=%0d required 3 3", sc_w[2], mc_w[2]);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            s_valid[d] = 1'b0;
            s_inp[d]   = '0;
            m_ready[d] = 1'b1;
            mlp_out[d] = '0;
        end
        test_reset();
        test_basic();
        test_mismatch();
        test_backpressure();
        test_no_check();
        test_back_to_back();
        test_reset_midflight();
        test_saturation();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries remain, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
